// File: rtl/udp_tx_pattern_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : udp_tx_pattern_gen                                         |
// | Description : UDP test-traffic source. Resolves the peer MAC via ARP,    |
// |               then emits one UDP payload of selectable length/pattern    |
// |               per PERIOD_CNT cycles, re-ARPing on a MAC cache miss.      |
// |               Optional burst mode under macro UDP_TX_BURST_EN.           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module udp_tx_pattern_gen #(
   parameter int unsigned LEN_MAX     = 1472,
   parameter int unsigned PERIOD_CNT  = 125_000_000,
   parameter int unsigned ACK_TIMEOUT = 65535,
   parameter logic [7:0]  FILL_BYTE   = 8'h55
`ifdef UDP_TX_BURST_EN
   ,
   parameter int unsigned IFG_CNT     = 12
`endif
) (
   input  logic        rgmii_clk,
   input  logic        rstn,
   input  logic        enable,
   input  logic [15:0] payload_len,
   input  logic [1:0]  pattern_mode,
   output logic        arp_req,
   input  logic        arp_found,
   input  logic        mac_not_exist,
   input  logic        mac_send_end,
   output logic        app_data_request,
   input  logic        udp_send_ack,
   output logic        app_data_in_valid,
   output logic [7:0]  app_data_in,
   output logic [15:0] app_data_length,
   output logic [31:0] frame_cnt,
   output logic [15:0] err_cnt,
`ifdef UDP_TX_BURST_EN
   input  logic [7:0]  burst_len,
`endif
   output logic        busy
);

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_ARP_REQ  = 4'd1,
      S_ARP_SEND = 4'd2,
      S_ARP_WAIT = 4'd3,
      S_GAP      = 4'd4,
      S_CHECK    = 4'd5,
      S_GEN_REQ  = 4'd6,
      S_WRITE    = 4'd7,
      S_TX_WAIT  = 4'd8,
      S_IFG      = 4'd9
   } state_t;

   localparam logic [31:0] PERIOD_LAST = 32'(PERIOD_CNT - 1);
   localparam logic [31:0] ACK_LAST    = 32'(ACK_TIMEOUT - 1);
   localparam logic [15:0] LEN_LIMIT   = 16'(LEN_MAX);
`ifdef UDP_TX_BURST_EN
   localparam logic [31:0] IFG_LAST    = 32'(IFG_CNT - 1);
`endif

   state_t      state_q, state_d;
   logic [31:0] wait_cnt_q, wait_cnt_d;
   logic [31:0] tmo_cnt_q, tmo_cnt_d;
   logic [15:0] len_q, len_d;
   logic [1:0]  mode_q, mode_d;
   logic [15:0] idx_q, idx_d;
   logic [7:0]  prbs_q, prbs_d;
   logic [31:0] frame_cnt_q, frame_cnt_d;
   logic [15:0] err_cnt_q, err_cnt_d;
   logic        tmo_hit;
   logic        err_inc;
   logic        tx_done;
`ifdef UDP_TX_BURST_EN
   logic [7:0]  burst_cnt_q, burst_cnt_d;
   logic [8:0]  burst_goal;
`endif

   // Advance the x^8+x^6+x^5+x^4+1 Fibonacci LFSR by one byte (8 shifts)
   function automatic logic [7:0] prbs_adv8(input logic [7:0] s);
      logic [7:0] r;
      r = s;
      for (int k = 0; k < 8; k++) begin
         r = {r[6:0], r[7] ^ r[5] ^ r[4] ^ r[3]};
      end
      return r;
   endfunction

   assign tmo_hit = (tmo_cnt_q == ACK_LAST);
`ifdef UDP_TX_BURST_EN
   assign burst_goal = (burst_len == 8'd0) ? 9'd1 : {1'b0, burst_len};
`endif

   // Next-state logic and per-frame bookkeeping
   always_comb begin
      state_d     = state_q;
      err_inc     = 1'b0;
      tx_done     = 1'b0;
      frame_cnt_d = frame_cnt_q;
      case (state_q)
         S_IDLE:     if (enable) state_d = S_ARP_REQ;
         S_ARP_REQ:  state_d = S_ARP_SEND;
         S_ARP_SEND: begin
            if (mac_send_end) begin
               state_d = S_ARP_WAIT;
            end else if (tmo_hit) begin
               err_inc = 1'b1;
               state_d = S_ARP_REQ;
            end
         end
         S_ARP_WAIT: begin
            if (arp_found)                       state_d = S_GAP;
            else if (wait_cnt_q == PERIOD_LAST)  state_d = S_ARP_REQ;
         end
         S_GAP: begin
            if (!enable)                         state_d = S_IDLE;
            else if (wait_cnt_q == PERIOD_LAST)  state_d = S_CHECK;
         end
         S_CHECK:    state_d = mac_not_exist ? S_ARP_REQ : S_GEN_REQ;
         S_GEN_REQ: begin
            if (udp_send_ack) begin
               state_d = S_WRITE;
            end else if (tmo_hit) begin
               err_inc = 1'b1;
               state_d = S_CHECK;
            end
         end
         S_WRITE:    if (idx_q == len_q - 16'd1) state_d = S_TX_WAIT;
         S_TX_WAIT: begin
            if (mac_send_end) begin
               frame_cnt_d = frame_cnt_q + 32'd1;
               tx_done     = 1'b1;
            end else if (tmo_hit) begin
               err_inc = 1'b1;
               tx_done = 1'b1;
            end
`ifdef UDP_TX_BURST_EN
            if (tx_done) begin
               state_d = (({1'b0, burst_cnt_q} + 9'd1) < burst_goal) ? S_IFG : S_GAP;
            end
`else
            if (tx_done) state_d = S_GAP;
`endif
         end
`ifdef UDP_TX_BURST_EN
         S_IFG:      if (wait_cnt_q == IFG_LAST) state_d = S_CHECK;
`endif
         default:    state_d = S_IDLE;
      endcase

      err_cnt_d = (err_inc && err_cnt_q != 16'hFFFF) ? err_cnt_q + 16'd1 : err_cnt_q;

      // Both counters restart on every state change
      wait_cnt_d = wait_cnt_q;
      tmo_cnt_d  = tmo_cnt_q;
      if (state_d != state_q) begin
         wait_cnt_d = 32'd0;
         tmo_cnt_d  = 32'd0;
      end else begin
         if (state_q == S_IDLE || state_q == S_ARP_WAIT || state_q == S_GAP || state_q == S_IFG)
            wait_cnt_d = wait_cnt_q + 32'd1;
         if (state_q == S_ARP_SEND || state_q == S_GEN_REQ || state_q == S_TX_WAIT)
            tmo_cnt_d = tmo_cnt_q + 32'd1;
      end

      // Length and pattern are captured only when GEN_REQ is entered
      len_d  = len_q;
      mode_d = mode_q;
      if (state_d == S_GEN_REQ && state_q != S_GEN_REQ) begin
         if (payload_len == 16'd0)          len_d = 16'd1;
         else if (payload_len > LEN_LIMIT)  len_d = LEN_LIMIT;
         else                               len_d = payload_len;
         mode_d = pattern_mode;
      end

      // Byte index and PRBS state run only while streaming; reseeded otherwise
      idx_d  = (state_q == S_WRITE) ? idx_q + 16'd1 : 16'd0;
      prbs_d = (state_q == S_WRITE) ? prbs_adv8(prbs_q) : 8'hFF;

`ifdef UDP_TX_BURST_EN
      burst_cnt_d = burst_cnt_q;
      if (state_d == S_GAP && state_q != S_GAP) burst_cnt_d = 8'd0;
      else if (tx_done)                         burst_cnt_d = burst_cnt_q + 8'd1;
`endif
   end

   // State and counter registers
   always_ff @(posedge rgmii_clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= S_IDLE;
         wait_cnt_q  <= 32'd0;
         tmo_cnt_q   <= 32'd0;
         len_q       <= 16'd0;
         mode_q      <= 2'd0;
         idx_q       <= 16'd0;
         prbs_q      <= 8'hFF;
         frame_cnt_q <= 32'd0;
         err_cnt_q   <= 16'd0;
`ifdef UDP_TX_BURST_EN
         burst_cnt_q <= 8'd0;
`endif
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         tmo_cnt_q   <= tmo_cnt_d;
         len_q       <= len_d;
         mode_q      <= mode_d;
         idx_q       <= idx_d;
         prbs_q      <= prbs_d;
         frame_cnt_q <= frame_cnt_d;
         err_cnt_q   <= err_cnt_d;
`ifdef UDP_TX_BURST_EN
         burst_cnt_q <= burst_cnt_d;
`endif
      end
   end

   // Payload byte selection for the current index
   always_comb begin
      app_data_in = 8'd0;
      if (state_q == S_WRITE) begin
         case (mode_q)
            2'd0: app_data_in = idx_q[7:0];
            2'd1: app_data_in = FILL_BYTE;
            2'd2: begin
               if (idx_q < 16'd4) begin
                  case (idx_q[1:0])
                     2'd0:    app_data_in = frame_cnt_q[31:24];
                     2'd1:    app_data_in = frame_cnt_q[23:16];
                     2'd2:    app_data_in = frame_cnt_q[15:8];
                     default: app_data_in = frame_cnt_q[7:0];
                  endcase
               end else begin
                  app_data_in = idx_q[7:0] - 8'd4;
               end
            end
            default: app_data_in = prbs_q;
         endcase
      end
   end

   assign arp_req           = (state_q == S_ARP_REQ);
   assign app_data_request  = (state_q == S_GEN_REQ);
   assign app_data_in_valid = (state_q == S_WRITE);
   assign app_data_length   = len_q;
   assign frame_cnt         = frame_cnt_q;
   assign err_cnt           = err_cnt_q;
   assign busy              = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_udp_tx_pattern_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_udp_tx_pattern_gen                                      |
// | Description : Self-checking bench for udp_tx_pattern_gen; plays the      |
// |               MAC/ARP side and predicts payloads from a byte model.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_udp_tx_pattern_gen;

   localparam int LEN_MAX = 1472;
   localparam int PERIOD  = 1000;
   localparam int ACK_TO  = 100;

   logic        rgmii_clk = 1'b0;
   logic        rstn = 1'b0;
   logic        enable = 1'b0;
   logic [15:0] payload_len = 16'd0;
   logic [1:0]  pattern_mode = 2'd0;
   logic        arp_found = 1'b0;
   logic        mac_not_exist = 1'b0;
   logic        mac_send_end = 1'b0;
   logic        udp_send_ack = 1'b0;
   logic        arp_req;
   logic        app_data_request;
   logic        app_data_in_valid;
   logic [7:0]  app_data_in;
   logic [15:0] app_data_length;
   logic [31:0] frame_cnt;
   logic [15:0] err_cnt;
   logic        busy;
`ifdef UDP_TX_BURST_EN
   logic [7:0]  burst_len = 8'd1;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int m_frames = 0;
   int m_errs   = 0;
   int arp_pulses = 0;
   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];

   udp_tx_pattern_gen #(
      .LEN_MAX(LEN_MAX), .PERIOD_CNT(PERIOD), .ACK_TIMEOUT(ACK_TO), .FILL_BYTE(8'h55)
   ) dut (
      .rgmii_clk(rgmii_clk), .rstn(rstn), .enable(enable),
      .payload_len(payload_len), .pattern_mode(pattern_mode),
      .arp_req(arp_req), .arp_found(arp_found), .mac_not_exist(mac_not_exist),
      .mac_send_end(mac_send_end), .app_data_request(app_data_request),
      .udp_send_ack(udp_send_ack), .app_data_in_valid(app_data_in_valid),
      .app_data_in(app_data_in), .app_data_length(app_data_length),
      .frame_cnt(frame_cnt), .err_cnt(err_cnt),
`ifdef UDP_TX_BURST_EN
      .burst_len(burst_len),
`endif
      .busy(busy)
   );

   always #4 rgmii_clk = ~rgmii_clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One PRBS byte step derived from the polynomial's tap exponents
   function automatic logic [7:0] prbs_next_byte(input logic [7:0] s);
      int taps[4] = '{8, 6, 5, 4};
      logic [7:0] r;
      logic fb;
      r = s;
      for (int step = 0; step < 8; step++) begin
         fb = 1'b0;
         for (int t = 0; t < 4; t++) fb = fb ^ r[taps[t] - 1];
         r = {r[6:0], fb};
      end
      return r;
   endfunction

   function automatic int clamp_len(input int req);
      if (req == 0) return 1;
      if (req > LEN_MAX) return LEN_MAX;
      return req;
   endfunction

   // Expected payload of a whole frame
   task automatic build(input int len, input int mode, input logic [31:0] fc);
      logic [7:0] lfsr;
      logic [7:0] b;
      exp_q.delete();
      lfsr = 8'hFF;
      for (int i = 0; i < len; i++) begin
         case (mode)
            0: b = 8'(i % 256);
            1: b = 8'h55;
            2: b = (i < 4) ? 8'(fc >> (8 * (3 - i))) : 8'((i - 4) % 256);
            default: begin
               b = lfsr;
               lfsr = prbs_next_byte(lfsr);
            end
         endcase
         exp_q.push_back(b);
      end
   endtask

   // Every-cycle comparison of counters and streamed bytes against the model
   always @(negedge rgmii_clk) begin
      if (rstn) begin
         chk("frame_cnt", frame_cnt, 32'(m_frames));
         chk("err_cnt", {16'd0, err_cnt}, 32'(m_errs));
         if (arp_req) arp_pulses++;
         if (app_data_in_valid) begin
            got_q.push_back(app_data_in);
            chk("byte_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) chk("payload_byte", {24'd0, app_data_in}, {24'd0, exp_q.pop_front()});
         end
      end
   end

   task automatic tick();
      @(posedge rgmii_clk);
      #1;
   endtask

   task automatic wait_req(output int n);
      n = 0;
      while (!app_data_request && n < 3 * PERIOD) begin
         tick();
         n++;
      end
      chk("req_seen", {31'd0, app_data_request}, 32'd1);
   endtask

   task automatic do_arp(input int send_delay, input int found_delay);
      int n;
      n = 0;
      while (!arp_req && n < 50) begin
         tick();
         n++;
      end
      chk("arp_req_seen", {31'd0, arp_req}, 32'd1);
      tick();
      chk("arp_req_one_cycle", {31'd0, arp_req}, 32'd0);
      repeat (send_delay) tick();
      mac_send_end = 1'b1;
      tick();
      mac_send_end = 1'b0;
      repeat (found_delay) tick();
      arp_found = 1'b1;
      tick();
      arp_found = 1'b0;
   endtask

   // Request, ack and stream a frame; exp_gap < 0 skips the spacing check
   task automatic start_frame(input int len_req, input int mode, input int ack_delay, input int exp_gap,
                              output int len);
      int n;
      payload_len  = 16'(len_req);
      pattern_mode = 2'(mode);
      wait_req(n);
      if (exp_gap >= 0) chk("gap_cycles", n, exp_gap);
      len = clamp_len(len_req);
      chk("app_data_length", {16'd0, app_data_length}, 32'(len));
      chk("busy_in_frame", {31'd0, busy}, 32'd1);
      build(len, mode, 32'(m_frames));
      got_q.delete();
      repeat (ack_delay) begin
         tick();
         chk("req_held", {31'd0, app_data_request}, 32'd1);
      end
      udp_send_ack = 1'b1;
      tick();
      udp_send_ack = 1'b0;
      // Later changes must not affect the frame already latched
      payload_len  = 16'($urandom_range(0, 65535));
      pattern_mode = 2'($urandom_range(0, 3));
   endtask

   task automatic do_frame(input int len_req, input int mode, input int ack_delay, input int end_delay,
                           input int exp_gap);
      int len;
      start_frame(len_req, mode, ack_delay, exp_gap, len);
      for (int k = 0; k < len; k++) begin
         chk("valid_run", {31'd0, app_data_in_valid}, 32'd1);
         tick();
      end
      chk("valid_end", {31'd0, app_data_in_valid}, 32'd0);
      chk("bytes_all_seen", exp_q.size(), 32'd0);
      repeat (end_delay) tick();
      mac_send_end = 1'b1;
      tick();
      mac_send_end = 1'b0;
      m_frames++;
   endtask

   initial begin
      #1000000;
      n_fail++;
      $display("FAIL watchdog: got timeout expected finish at %0t", $time);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int n;
      int len;
      logic [7:0] pin2[6];
      logic [7:0] pin2r[6];
      logic [7:0] pin3[3];
      pin2  = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h01};
      pin2r = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
      pin3  = '{8'hFF, 8'h0B, 8'hC6};

      #20;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_arp_req", {31'd0, arp_req}, 32'd0);
      chk("rst_valid", {31'd0, app_data_in_valid}, 32'd0);
      chk("rst_frame_cnt", frame_cnt, 32'd0);
      tick();
      rstn = 1'b1;
      enable = 1'b1;

      do_arp(10, 50);
      chk("arp_pulses_first", arp_pulses, 32'd1);

      do_frame(20, 0, 5, 7, PERIOD + 1);
      chk("f1_count", got_q.size(), 32'd20);
      for (int i = 0; i < 20; i++) chk("f1_inc_byte", {24'd0, got_q[i]}, 32'(i));
      chk("f1_frame_cnt", frame_cnt, 32'd1);

      do_frame(0, 1, 2, 3, PERIOD + 1);
      chk("f2_len1", got_q.size(), 32'd1);
      chk("f2_fill", {24'd0, got_q[0]}, 32'h55);

      do_frame(6, 2, 1, 4, PERIOD + 1);
      for (int i = 0; i < 6; i++) chk("f3_seq_hdr", {24'd0, got_q[i]}, {24'd0, pin2[i]});

      do_frame(3000, 1, 0, 2, PERIOD + 1);
      chk("f4_clamped", got_q.size(), 32'd1472);

      do_frame(3, 3, 3, 1, PERIOD + 1);
      for (int i = 0; i < 3; i++) chk("f5_prbs", {24'd0, got_q[i]}, {24'd0, pin3[i]});

      // Ack never arrives: first timeout re-enters CHECK then GEN_REQ
      payload_len = 16'd8;
      wait_req(n);
      chk("gap_before_timeout", n, PERIOD + 1);
      n = 0;
      while (app_data_request && n < 3 * ACK_TO) begin
         tick();
         n++;
      end
      chk("ack_timeout_cycles", n, ACK_TO);
      m_errs++;
      chk("check_no_req", {31'd0, app_data_request}, 32'd0);
      tick();
      chk("check_then_req", {31'd0, app_data_request}, 32'd1);
      // Second timeout with a cache miss at CHECK forces a new ARP
      mac_not_exist = 1'b1;
      n = 0;
      while (app_data_request && n < 3 * ACK_TO) begin
         tick();
         n++;
      end
      chk("ack_timeout_cycles2", n, ACK_TO);
      m_errs++;
      tick();
      chk("miss_arp_req", {31'd0, arp_req}, 32'd1);
      mac_not_exist = 1'b0;
      do_arp(5, 20);
      chk("arp_pulses_after_miss", arp_pulses, 32'd2);

      for (int r = 0; r < 4; r++) begin
         int lr;
         lr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1400, 2000)) : int'($urandom_range(0, 80));
         do_frame(lr, int'($urandom_range(0, 3)), int'($urandom_range(0, 10)),
                  int'($urandom_range(0, 20)), PERIOD + 1);
      end

      // Asynchronous reset in the middle of a payload
      start_frame(50, 0, 2, PERIOD + 1, len);
      repeat (10) tick();
      rstn = 1'b0;
      #1;
      chk("rst_mid_valid", {31'd0, app_data_in_valid}, 32'd0);
      chk("rst_mid_req", {31'd0, app_data_request}, 32'd0);
      chk("rst_mid_busy", {31'd0, busy}, 32'd0);
      chk("rst_mid_data", {24'd0, app_data_in}, 32'd0);
      chk("rst_mid_len", {16'd0, app_data_length}, 32'd0);
      chk("rst_mid_frames", frame_cnt, 32'd0);
      chk("rst_mid_errs", {16'd0, err_cnt}, 32'd0);
      exp_q.delete();
      m_frames = 0;
      m_errs = 0;
      arp_pulses = 0;
      tick();
      rstn = 1'b1;
      do_arp(8, 30);
      chk("arp_pulses_after_reset", arp_pulses, 32'd1);
      do_frame(6, 2, 0, 0, PERIOD + 1);
      for (int i = 0; i < 6; i++) chk("post_rst_seq_hdr", {24'd0, got_q[i]}, {24'd0, pin2r[i]});

      // Disable while in GAP returns to idle with no further ARP
      enable = 1'b0;
      tick();
      chk("disable_idle", {31'd0, busy}, 32'd0);
      repeat (40) tick();
      chk("disable_no_arp", arp_pulses, 32'd1);
      chk("disable_still_idle", {31'd0, busy}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
